regfile_dump_reader: RTL and testbench
======================================

Name: regfile_dump_reader

Overview:
- Hardware read-out engine for the multi-ported load-initialisable register file.
- On command, walks an address range through one asynchronous read port and streams {address, data} beats over a valid/ready interface.
- Consumers: debug/trace unit, checkpoint logic, and the ASIC bring-up scan path.
- It is the counterpart of the file-based initial load: state leaves the array instead of entering it.

Parameters:
- addr_width, 5, width of register file address.
- data_width, 64, width of register file entry.
- lo, 0, lowest legal address of the array.
- hi, 31, highest legal address of the array (hi >= lo, hi <= 2^addr_width-1).

Ports:
- CLK  in  1  sole clock; all state updates on posedge.
- RST_N  in  1  reset; synchronous, active-low.
- START_EN  in  1  dump request; sampled only when START_RDY=1.
- START_LO  in  addr_width  first address to dump.
- START_HI  in  addr_width  last address to dump (inclusive).
- START_RDY  out  1  high in IDLE only.
- RF_ADDR  out  addr_width  drives a register file read address port.
- RF_DATA  in  data_width  the matching read data port; combinational same cycle.
- OUT_VALID  out  1  head beat valid.
- OUT_ADDR  out  addr_width  address of head beat.
- OUT_DATA  out  data_width  data of head beat.
- OUT_READY  in  1  consumer accepts head beat when OUT_VALID&&OUT_READY.
- BUSY  out  1  high in RUN or DRAIN.
- DONE  out  1  one-cycle pulse: dump complete.
- ERR  out  1  one-cycle pulse: request rejected.

Behaviour:
- Reset (RST_N=0 at posedge), including mid-dump:
  - state=IDLE, FIFO flushed.
  - OUT_VALID=0, OUT_ADDR=0, OUT_DATA=0.
  - DONE=0, ERR=0, BUSY=0, START_RDY=1.
  - RF_ADDR=lo, cur=lo, end=lo.
  - No beat or DONE is emitted for an aborted dump.
- IDLE:
  - START_EN with START_LO<=START_HI and both within [lo,hi]: cur<=START_LO, end<=START_HI, go RUN.
  - Otherwise, on START_EN: ERR pulses next cycle and state stays IDLE.
- RUN:
  - RF_ADDR=cur.
  - capture = (count<2) || (count==2 && OUT_VALID && OUT_READY).
  - On capture, {cur, RF_DATA} is enqueued.
  - If cur==end: go DRAIN. The comparison is done before increment, so no overflow occurs when end = 2^addr_width-1.
  - Else cur<=cur+1.
  - RF_ADDR holds while capture=0.
- DRAIN:
  - Waits for the FIFO to empty.
  - When the final beat handshakes, state<=IDLE and DONE=1 in the following cycle.
  - START_RDY returns high in that same cycle.
- Output buffer:
  - 2-entry FIFO with registered outputs; OUT_* are driven from the head entry.
  - Enqueue and dequeue in the same cycle are allowed at any occupancy, including full.
  - Beats leave in strictly ascending address order; none are dropped or duplicated.
  - OUT_ADDR and OUT_DATA are stable while OUT_VALID=1 and OUT_READY=0.
- Latency and throughput:
  - START_EN accepted in cycle t; first capture at the end of t+1; OUT_VALID=1 at t+2.
  - With OUT_READY held high, throughput is one beat per cycle.
  - An N-entry dump gives DONE at t+N+2.
- Coherence:
  - A captured word equals the array contents in its capture cycle.
  - A write landing at the same edge is not visible; a later write is not reflected.
- Concurrency:
  - START_EN while BUSY is ignored, with no ERR.
  - DONE and ERR are never high in the same cycle.
- BUSY equals !START_RDY.
- Single-entry dump (START_LO==START_HI) is legal: exactly one beat.

Test Plan:
- Reset, then START lo=0 hi=31, OUT_READY=1, array preloaded with data=addr*3 -> 32 beats at t+2..t+33, addresses 0..31, data 0,3,...,93; DONE only at t+34.
- START 5..8 with OUT_READY toggling 1,0,0,1,0,1... -> beats 5,6,7,8 in order, head stable while stalled, no loss or duplicate; FIFO never exceeds 2 entries; DONE one cycle after the 4th handshake.
- START lo=9 hi=4, and separately hi=40 with hi param 31 -> ERR pulse one cycle, no OUT_VALID, START_RDY stays 1.
- addr_width=3, lo=0, hi=7, START 6..7 -> beats 6,7 then DONE; no wrap to address 0.
- Deassert RST_N mid-dump after 3 beats -> next cycle OUT_VALID=0, BUSY=0, no DONE; a fresh START 0..1 then dumps normally.
- START_EN pulsed while BUSY, plus a write to the current address at its capture edge -> second START ignored; the captured word is the pre-write value, and the next dump shows the new value.

Source files
------------

// File: rtl/regfile_dump_reader.sv
// Register file dump engine: walks an inclusive address range through one
// asynchronous read port and streams {address, data} beats over valid/ready.
module regfile_dump_reader #(
  parameter int unsigned addr_width = 5,
  parameter int unsigned data_width = 64,
  parameter int unsigned lo         = 0,
  parameter int unsigned hi         = 31
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START_EN,
  input  logic [addr_width-1:0] START_LO,
  input  logic [addr_width-1:0] START_HI,
  output logic                  START_RDY,
  output logic [addr_width-1:0] RF_ADDR,
  input  logic [data_width-1:0] RF_DATA,
  output logic                  OUT_VALID,
  output logic [addr_width-1:0] OUT_ADDR,
  output logic [data_width-1:0] OUT_DATA,
  input  logic                  OUT_READY,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR
);

  localparam logic [addr_width-1:0] LO_A  = addr_width'(lo);
  localparam logic [addr_width-1:0] ONE_A = addr_width'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [addr_width-1:0] addr;
    logic [data_width-1:0] data;
  } beat_t;

  state_e                state_q, state_d;
  logic [addr_width-1:0] cur_q, cur_d;
  logic [addr_width-1:0] last_q, last_d;
  logic [1:0]            cnt_q, cnt_d;
  beat_t                 head_q, head_d;
  beat_t                 tail_q, tail_d;
  logic                  out_valid_q, out_valid_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  start_rdy_q, start_rdy_d;

  logic                  lo_ok_c, hi_ok_c, range_ok_c;
  logic                  pop_c, capture_c;
  beat_t                 new_beat_c;

  // Request bounds checks; a bound equal to the address-space edge needs no compare
  if (lo == 0) begin : g_lo_floor
    assign lo_ok_c = 1'b1;
  end else begin : g_lo_check
    assign lo_ok_c = (START_LO >= LO_A);
  end

  if (64'(hi) >= ((64'd1 << addr_width) - 64'd1)) begin : g_hi_ceiling
    assign hi_ok_c = 1'b1;
  end else begin : g_hi_check
    localparam logic [addr_width-1:0] HI_A = addr_width'(hi);
    assign hi_ok_c = (START_HI <= HI_A);
  end

  assign range_ok_c = (START_LO <= START_HI) && lo_ok_c && hi_ok_c;

  // Handshake on the head beat, and whether the read port result is taken this cycle
  assign pop_c      = out_valid_q && OUT_READY;
  assign capture_c  = (state_q == ST_RUN) &&
                      ((cnt_q < 2'd2) || ((cnt_q == 2'd2) && pop_c));
  assign new_beat_c = '{addr: cur_q, data: RF_DATA};

  // Sequencer next state: accept/reject requests, walk addresses, wait for drain
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START_EN) begin
          if (range_ok_c) begin
            cur_d   = START_LO;
            last_d  = START_HI;
            state_d = ST_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // Compare before incrementing so the top address never wraps
        if (capture_c) begin
          if (cur_q == last_q) begin
            state_d = ST_DRAIN;
          end else begin
            cur_d = cur_q + ONE_A;
          end
        end
      end
      ST_DRAIN: begin
        if (pop_c && (cnt_q == 2'd1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d      = (state_d != ST_IDLE);
    start_rdy_d = (state_d == ST_IDLE);
  end

  // Two-entry output buffer; head entry drives the output port directly
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({capture_c, pop_c})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          head_d = new_beat_c;
        end else begin
          tail_d = new_beat_c;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        if (cnt_q == 2'd2) begin
          head_d = tail_q;
        end
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged; a pop implies at least one entry present
        if (cnt_q == 2'd1) begin
          head_d = new_beat_c;
        end else begin
          head_d = tail_q;
          tail_d = new_beat_c;
        end
      end
      default: ;
    endcase
    out_valid_d = (cnt_d != 2'd0);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      cur_q       <= LO_A;
      last_q      <= LO_A;
      cnt_q       <= 2'd0;
      head_q      <= '0;
      tail_q      <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      start_rdy_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      start_rdy_q <= start_rdy_d;
    end
  end

  assign START_RDY = start_rdy_q;
  assign RF_ADDR   = cur_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_ADDR  = head_q.addr;
  assign OUT_DATA  = head_q.data;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: table-driven and random dump requests checked
// against a queue of expected beats built from the array image.
`timescale 1ns/1ps
module tb_regfile_dump_reader;

  localparam int unsigned AW  = 6;
  localparam int unsigned DW  = 64;
  localparam int unsigned LO  = 0;
  localparam int unsigned HI  = 31;
  localparam int unsigned SAW = 3;
  localparam int unsigned SDW = 16;

  logic CLK;
  logic rst_n;

  // Main instance: 6-bit address space, legal window 0..31
  logic          start_en, start_rdy, out_valid, out_ready, busy, done, err;
  logic [AW-1:0] start_lo, start_hi, rf_addr, out_addr;
  logic [DW-1:0] rf_data, out_data;

  // Small instance: full 3-bit address space, exercises the top-address edge
  logic           s_start_en, s_start_rdy, s_out_valid, s_out_ready, s_busy, s_done, s_err;
  logic [SAW-1:0] s_start_lo, s_start_hi, s_rf_addr, s_out_addr;
  logic [SDW-1:0] s_rf_data, s_out_data;

  logic [DW-1:0] mem [64];
  logic [DW-1:0] img [64];
  logic          load_req, wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  typedef struct {
    int       addr;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct {
    int lo;
    int hi;
    int mode;
    bit exp_err;
  } vec_t;

  beat_t exp_q[$];
  vec_t  vecs[9];
  int    nvec = 0;
  int    nerr = 0;

  regfile_dump_reader #(.addr_width(AW), .data_width(DW), .lo(LO), .hi(HI)) u_dut (
    .CLK(CLK), .RST_N(rst_n),
    .START_EN(start_en), .START_LO(start_lo), .START_HI(start_hi), .START_RDY(start_rdy),
    .RF_ADDR(rf_addr), .RF_DATA(rf_data),
    .OUT_VALID(out_valid), .OUT_ADDR(out_addr), .OUT_DATA(out_data), .OUT_READY(out_ready),
    .BUSY(busy), .DONE(done), .ERR(err)
  );

  regfile_dump_reader #(.addr_width(SAW), .data_width(SDW), .lo(0), .hi(7)) u_small (
    .CLK(CLK), .RST_N(rst_n),
    .START_EN(s_start_en), .START_LO(s_start_lo), .START_HI(s_start_hi), .START_RDY(s_start_rdy),
    .RF_ADDR(s_rf_addr), .RF_DATA(s_rf_data),
    .OUT_VALID(s_out_valid), .OUT_ADDR(s_out_addr), .OUT_DATA(s_out_data), .OUT_READY(s_out_ready),
    .BUSY(s_busy), .DONE(s_done), .ERR(s_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Register array model: asynchronous read, writes land at the clock edge
  assign rf_data   = mem[rf_addr];
  assign s_rf_data = SDW'(s_rf_addr) * SDW'(5) + SDW'(1);

  always @(posedge CLK) begin
    if (load_req) begin
      for (int i = 0; i < 64; i++) mem[i] <= img[i];
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_bit(input string name, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_image(input int kind);
    for (int i = 0; i < 64; i++) img[i] = (kind == 0) ? DW'(i * 3) : {$urandom, $urandom};
    @(negedge CLK);
    load_req = 1'b1;
    @(negedge CLK);
    load_req = 1'b0;
  endtask

  // One dump request. mode: 0 ready high, 1 toggling, 2 random, 3 long initial stall.
  // busy_k: cycle after acceptance at which a second request is pulsed (0 = none).
  // wr_k: cycle whose closing edge writes wr_d to wr_a (0 = none; mode 0 only).
  task automatic run_dump(input int lo, input int hi, input int mode, input bit exp_err,
                          input int busy_k, input int wr_k, input int wr_a,
                          input logic [DW-1:0] wr_d);
    int    n, k, hs_cnt, ph;
    bit    done_due;
    logic  rdy;
    beat_t b;
    exp_q.delete();
    if (!exp_err) begin
      for (int a = lo; a <= hi; a++) begin
        b.addr = a;
        b.data = mem[a];
        exp_q.push_back(b);
      end
    end
    n = exp_q.size();
    @(negedge CLK);
    chk_bit("idle_done_low", done, 1'b0);
    chk_bit("idle_start_rdy", start_rdy, 1'b1);
    start_en  = 1'b1;
    start_lo  = AW'(lo);
    start_hi  = AW'(hi);
    out_ready = 1'b1;
    @(negedge CLK);
    start_en = 1'b0;
    if (exp_err) begin
      chk_bit("err_pulse", err, 1'b1);
      chk_bit("err_no_done", done, 1'b0);
      chk_bit("err_no_valid", out_valid, 1'b0);
      chk_bit("err_start_rdy", start_rdy, 1'b1);
      chk_bit("err_busy", busy, 1'b0);
      @(negedge CLK);
      chk_bit("err_one_cycle", err, 1'b0);
      chk_bit("err_no_valid2", out_valid, 1'b0);
      chk_bit("err_start_rdy2", start_rdy, 1'b1);
      return;
    end
    k = 1;
    hs_cnt = 0;
    done_due = 1'b0;
    while (1) begin
      chk_bit("no_err_in_dump", err, 1'b0);
      chk_bit("done", done, done_due);
      if (done_due) begin
        chk_bit("start_rdy_after_done", start_rdy, 1'b1);
        chk_bit("busy_after_done", busy, 1'b0);
        chk_bit("valid_after_done", out_valid, 1'b0);
        if (mode == 0) chk_val("done_cycle", 64'(k), 64'(n + 2));
        break;
      end
      chk_bit("busy", busy, 1'b1);
      chk_bit("start_rdy_busy", start_rdy, 1'b0);
      chk_bit("buffer_bound", int'(rf_addr) <= lo + hs_cnt + 2, 1'b1);
      if (mode == 0) chk_bit("valid_timing", out_valid, (k >= 2) && (k <= n + 1));
      if (out_valid) begin
        chk_bit("beat_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          chk_val("out_addr", 64'(out_addr), 64'(exp_q[0].addr));
          chk_val("out_data", out_data, exp_q[0].data);
        end
      end
      if (k == busy_k) begin
        start_en = 1'b1;
        start_lo = '0;
        start_hi = AW'(1);
      end else begin
        start_en = 1'b0;
      end
      if (k == wr_k) begin
        wr_en   = 1'b1;
        wr_addr = AW'(wr_a);
        wr_data = wr_d;
        // A word is visible only to captures after the write edge (capture cycle = a-lo+1)
        for (int i = 0; i < exp_q.size(); i++)
          if (exp_q[i].addr == wr_a && (exp_q[i].addr - lo + 1) > k) exp_q[i].data = wr_d;
      end else begin
        wr_en = 1'b0;
      end
      ph = k % 6;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (ph == 0) || (ph == 3) || (ph == 5);
        2:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (k > 8);
      endcase
      out_ready = rdy;
      if (out_valid && rdy && exp_q.size() != 0) begin
        b = exp_q.pop_front();
        hs_cnt++;
        if (exp_q.size() == 0) done_due = 1'b1;
      end
      if (k > 500) begin
        nvec++;
        nerr++;
        $display("FAIL dump_timeout: got %0d beats, expected %0d", hs_cnt, n);
        break;
      end
      k++;
      @(negedge CLK);
    end
    start_en  = 1'b0;
    wr_en     = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    int lo_r, hi_r, mode_r, hs;
    vecs[0] = '{lo: 0,  hi: 31, mode: 0, exp_err: 1'b0};
    vecs[1] = '{lo: 5,  hi: 8,  mode: 1, exp_err: 1'b0};
    vecs[2] = '{lo: 9,  hi: 4,  mode: 0, exp_err: 1'b1};
    vecs[3] = '{lo: 3,  hi: 40, mode: 0, exp_err: 1'b1};
    vecs[4] = '{lo: 12, hi: 12, mode: 0, exp_err: 1'b0};
    vecs[5] = '{lo: 31, hi: 31, mode: 2, exp_err: 1'b0};
    vecs[6] = '{lo: 40, hi: 45, mode: 0, exp_err: 1'b1};
    vecs[7] = '{lo: 20, hi: 27, mode: 3, exp_err: 1'b0};
    vecs[8] = '{lo: 0,  hi: 31, mode: 2, exp_err: 1'b0};

    rst_n = 1'b0;
    start_en = 1'b0; start_lo = '0; start_hi = '0; out_ready = 1'b1;
    s_start_en = 1'b0; s_start_lo = '0; s_start_hi = '0; s_out_ready = 1'b1;
    load_req = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    load_image(0);
    @(negedge CLK);
    chk_bit("rst_start_rdy", start_rdy, 1'b1);
    chk_bit("rst_busy", busy, 1'b0);
    chk_bit("rst_valid", out_valid, 1'b0);
    chk_bit("rst_done", done, 1'b0);
    chk_bit("rst_err", err, 1'b0);
    chk_val("rst_rf_addr", 64'(rf_addr), 64'(LO));
    chk_val("rst_out_addr", 64'(out_addr), 64'd0);
    chk_val("rst_out_data", out_data, 64'd0);
    chk_bit("rst_s_start_rdy", s_start_rdy, 1'b1);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      run_dump(vecs[i].lo, vecs[i].hi, vecs[i].mode, vecs[i].exp_err, 0, 0, 0, '0);

    // Second request while busy is ignored; write at the capture edge of address 12 is not seen
    run_dump(10, 13, 0, 1'b0, 2, 3, 12, 64'hDEAD_BEEF_0000_0012);
    chk_val("coherence_new_value", mem[12], 64'hDEAD_BEEF_0000_0012);
    run_dump(12, 12, 0, 1'b0, 0, 0, 0, '0);

    // Reset in the middle of a dump after three beats have been accepted
    @(negedge CLK);
    start_en = 1'b1; start_lo = '0; start_hi = AW'(31); out_ready = 1'b1;
    @(negedge CLK);
    start_en = 1'b0;
    hs = 0;
    for (int c = 0; c < 12 && hs < 3; c++) begin
      @(negedge CLK);
      if (out_valid) begin
        chk_val("pre_rst_addr", 64'(out_addr), 64'(hs));
        chk_val("pre_rst_data", out_data, 64'(hs * 3));
        hs++;
      end
    end
    chk_val("pre_rst_beats", 64'(hs), 64'd3);
    @(negedge CLK);
    rst_n = 1'b0;
    @(negedge CLK);
    rst_n = 1'b1;
    chk_bit("mid_rst_valid", out_valid, 1'b0);
    chk_bit("mid_rst_busy", busy, 1'b0);
    chk_bit("mid_rst_start_rdy", start_rdy, 1'b1);
    chk_bit("mid_rst_done", done, 1'b0);
    chk_val("mid_rst_rf_addr", 64'(rf_addr), 64'(LO));
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      chk_bit("post_rst_no_done", done, 1'b0);
      chk_bit("post_rst_no_valid", out_valid, 1'b0);
    end
    run_dump(0, 1, 0, 1'b0, 0, 0, 0, '0);

    // Randomised requests over a fresh random image
    load_image(1);
    for (int i = 0; i < 10; i++) begin
      lo_r   = int'($urandom_range(0, 40));
      hi_r   = int'($urandom_range(0, 45));
      mode_r = int'($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0 && lo_r <= 31) hi_r = lo_r + int'($urandom_range(0, 31 - lo_r));
      run_dump(lo_r, hi_r, mode_r, !((lo_r <= hi_r) && (hi_r <= int'(HI)) && (lo_r >= int'(LO))),
               0, 0, 0, '0);
    end

    // Top of a 3-bit address space: beats 6 and 7 then DONE, no wrap to 0
    @(negedge CLK);
    s_start_en = 1'b1; s_start_lo = SAW'(6); s_start_hi = SAW'(7); s_out_ready = 1'b1;
    @(negedge CLK);
    s_start_en = 1'b0;
    chk_bit("s_k1_valid", s_out_valid, 1'b0);
    chk_bit("s_k1_busy", s_busy, 1'b1);
    chk_val("s_k1_rf_addr", 64'(s_rf_addr), 64'd6);
    @(negedge CLK);
    chk_bit("s_k2_valid", s_out_valid, 1'b1);
    chk_val("s_k2_addr", 64'(s_out_addr), 64'd6);
    chk_val("s_k2_data", 64'(s_out_data), 64'd31);
    @(negedge CLK);
    chk_bit("s_k3_valid", s_out_valid, 1'b1);
    chk_val("s_k3_addr", 64'(s_out_addr), 64'd7);
    chk_val("s_k3_data", 64'(s_out_data), 64'd36);
    chk_bit("s_k3_done", s_done, 1'b0);
    @(negedge CLK);
    chk_bit("s_k4_done", s_done, 1'b1);
    chk_bit("s_k4_valid", s_out_valid, 1'b0);
    chk_bit("s_k4_err", s_err, 1'b0);
    chk_bit("s_k4_start_rdy", s_start_rdy, 1'b1);
    chk_val("s_k4_rf_addr", 64'(s_rf_addr), 64'd7);
    @(negedge CLK);
    chk_bit("s_k5_done", s_done, 1'b0);
    chk_bit("s_k5_valid", s_out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
